// File: rtl/cpu_core_fsm.sv
// rtl/cpu_core_fsm.sv - multi-cycle CPU core: fetch/exec/wait/halt FSM, GPRs, flags, host program load
module cpu_core_fsm #(
  parameter int DW         = 16,
  parameter int NGPR       = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int WAIT_CYC   = 3
) (
  input  logic                          clk,
  input  logic                          sys_rst,
  input  logic [DW-1:0]                 din,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          resume,
  output logic [DW-1:0]                 dout,
  output logic [3:0]                    flags,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted
);
  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int GW  = (NGPR > 1) ? $clog2(NGPR) : 1;
  localparam int CW  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000, OP_MOV   = 5'b00001, OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011, OP_MUL   = 5'b00100, OP_ROR  = 5'b00101;
  localparam logic [4:0] OP_RAND    = 5'b00110, OP_RXOR  = 5'b00111, OP_RXNOR = 5'b01000;
  localparam logic [4:0] OP_RNAND   = 5'b01001, OP_RNOR  = 5'b01010, OP_RNOT = 5'b01011;
  localparam logic [4:0] OP_STOREREG = 5'b01101, OP_STOREDIN = 5'b01110, OP_SENDDOUT = 5'b01111;
  localparam logic [4:0] OP_SENDREG = 5'b10001, OP_JUMP  = 5'b10010, OP_JCARRY = 5'b10011;
  localparam logic [4:0] OP_JNOCARRY = 5'b10100, OP_JSIGN = 5'b10101, OP_JNOSIGN = 5'b10110;
  localparam logic [4:0] OP_JZERO   = 5'b10111, OP_JNOZERO = 5'b11000, OP_JOVF = 5'b11001;
  localparam logic [4:0] OP_JNOOVF  = 5'b11010, OP_HALT  = 5'b11011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [DW-1:0]   sgpr_q, sgpr_d;
  logic [3:0]      flags_q, flags_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]   gpr_q [NGPR];
  logic [31:0]     imem [IMEM_DEPTH];
  logic [DW-1:0]   dmem [DMEM_DEPTH];

  logic [4:0]      op;
  logic            imm;
  logic [15:0]     isrc;
  logic [GW-1:0]   rd_i, rs1_i, rs2_i;
  logic [DAW-1:0]  daddr;
  logic [DW-1:0]   isrc_ext, rs1_val, b_val;

  assign op       = ir_q[31:27];
  assign imm      = ir_q[16];
  assign isrc     = ir_q[15:0];
  assign rd_i     = GW'({1'b0, ir_q[26:22]} % 6'(NGPR));
  assign rs1_i    = GW'({1'b0, ir_q[21:17]} % 6'(NGPR));
  assign rs2_i    = GW'({1'b0, ir_q[15:11]} % 6'(NGPR));
  assign daddr    = isrc[DAW-1:0];
  assign isrc_ext = DW'(isrc);
  assign rs1_val  = gpr_q[rs1_i];
  assign b_val    = imm ? isrc_ext : gpr_q[rs2_i];

  logic [DW-1:0]   res;
  logic [DW:0]     sum_c;
  logic [2*DW-1:0] prod;
  logic            alu_c, alu_v, flag_op, is_mul, res_sign, res_zero;

  always_comb begin
    res     = '0;
    sum_c   = '0;
    prod    = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    flag_op = (op <= OP_RNOT);
    is_mul  = (op == OP_MUL);
    case (op)
      OP_MOVSGPR: res = sgpr_q;
      OP_MOV:     res = imm ? isrc_ext : rs1_val;
      OP_ADD: begin
        sum_c = {1'b0, rs1_val} + {1'b0, b_val};
        res   = sum_c[DW-1:0];
        alu_c = sum_c[DW];
        alu_v = (rs1_val[DW-1] == b_val[DW-1]) && (res[DW-1] != rs1_val[DW-1]);
      end
      OP_SUB: begin
        res   = rs1_val - b_val;
        alu_v = (rs1_val[DW-1] != b_val[DW-1]) && (res[DW-1] != rs1_val[DW-1]);
      end
      OP_MUL: begin
        prod = {{DW{1'b0}}, rs1_val} * {{DW{1'b0}}, b_val};
        res  = prod[DW-1:0];
      end
      OP_ROR:   res = rs1_val | b_val;
      OP_RAND:  res = rs1_val & b_val;
      OP_RXOR:  res = rs1_val ^ b_val;
      OP_RXNOR: res = rs1_val ~^ b_val;
      OP_RNAND: res = ~(rs1_val & b_val);
      OP_RNOR:  res = ~(rs1_val | b_val);
      OP_RNOT:  res = imm ? ~isrc_ext : ~rs1_val;
      default:  res = '0;
    endcase
    // mul reports sign/zero over the full double-width product
    res_sign = is_mul ? prod[2*DW-1] : res[DW-1];
    res_zero = is_mul ? (prod == '0) : (res == '0);
  end

  logic jmp_taken;
  always_comb begin
    case (op)
      OP_JUMP:     jmp_taken = 1'b1;
      OP_JCARRY:   jmp_taken = flags_q[0];
      OP_JNOCARRY: jmp_taken = ~flags_q[0];
      OP_JSIGN:    jmp_taken = flags_q[3];
      OP_JNOSIGN:  jmp_taken = ~flags_q[3];
      OP_JZERO:    jmp_taken = flags_q[2];
      OP_JNOZERO:  jmp_taken = ~flags_q[2];
      OP_JOVF:     jmp_taken = flags_q[1];
      OP_JNOOVF:   jmp_taken = ~flags_q[1];
      default:     jmp_taken = 1'b0;
    endcase
  end

  logic          gpr_we, dmem_we;
  logic [DW-1:0] gpr_wdata, dmem_wdata;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    sgpr_d     = sgpr_q;
    flags_d    = flags_q;
    dout_d     = dout_q;
    wait_cnt_d = wait_cnt_q;
    gpr_we     = 1'b0;
    gpr_wdata  = res;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d       = jmp_taken ? isrc[PCW-1:0] : pc_q + 1'b1;
        state_d    = (WAIT_CYC == 0) ? S_FETCH : S_WAIT;
        wait_cnt_d = '0;
        if (flag_op) begin
          gpr_we  = 1'b1;
          flags_d = {res_sign, res_zero, alu_v, alu_c};
        end
        if (is_mul) sgpr_d = prod[2*DW-1:DW];
        case (op)
          OP_STOREREG: begin
            dmem_we    = 1'b1;
            dmem_wdata = rs1_val;
          end
          OP_STOREDIN: begin
            dmem_we    = 1'b1;
            dmem_wdata = din;
          end
          OP_SENDDOUT: dout_d = dmem[daddr];
          OP_SENDREG: begin
            gpr_we    = 1'b1;
            gpr_wdata = dmem[daddr];
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (wait_cnt_q == CW'(WAIT_CYC - 1)) state_d = S_FETCH;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
          pc_d    = pc_q + 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      sgpr_q     <= '0;
      flags_q    <= '0;
      dout_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      sgpr_q     <= sgpr_d;
      flags_q    <= flags_d;
      dout_q     <= dout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NGPR; i++) gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[rd_i] <= gpr_wdata;
    end
  end

  // Memories are not reset; a write racing a fetch of the same word lands after the fetch
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[daddr] <= dmem_wdata;
  end

  assign dout   = dout_q;
  assign flags  = flags_q;
  assign pc     = pc_q;
  assign halted = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_core_fsm.sv
// tb/tb_cpu_core_fsm.sv - scoreboard bench for cpu_core_fsm
module tb_cpu_core_fsm;
  logic        clk = 1'b0;
  logic        sys_rst;
  logic [15:0] din;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        resume;
  logic [15:0] dout;
  logic [3:0]  flags;
  logic [3:0]  pc;
  logic        halted;

  cpu_core_fsm dut (
    .clk(clk), .sys_rst(sys_rst), .din(din), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .resume(resume), .dout(dout), .flags(flags), .pc(pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] MOVSGPR = 5'b00000, MOV = 5'b00001, ADD = 5'b00010, SUB = 5'b00011;
  localparam logic [4:0] MUL = 5'b00100, RXOR = 5'b00111, RNOT = 5'b01011;
  localparam logic [4:0] STOREREG = 5'b01101, STOREDIN = 5'b01110, SENDDOUT = 5'b01111;
  localparam logic [4:0] SENDREG = 5'b10001, JCARRY = 5'b10011, JOVF = 5'b11001;
  localparam logic [4:0] JNOOVF = 5'b11010, HALT = 5'b11011, UNDEF = 5'b11100, NOPOP = 5'b01100;

  typedef struct {
    logic [3:0]  pc;
    logic [3:0]  flags;
    logic [15:0] dout;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] ins_i(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [15:0] isrc);
    return {op, rd, rs1, 1'b1, isrc};
  endfunction

  function automatic logic [31:0] ins_r(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'b0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] f, input logic [15:0] d);
    exp_t e;
    e.pc = p; e.flags = f; e.dout = d;
    sb.push_back(e);
  endtask

  // Hold reset, write the whole program memory (NOP-filled), release reset
  task automatic load_prog();
    sys_rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      imem_we    = 1'b1;
      imem_addr  = 4'(i);
      imem_wdata = (i < prog.size()) ? prog[i] : {NOPOP, 27'b0};
      step(1);
    end
    imem_we = 1'b0;
    sys_rst = 1'b0;
  endtask

  task automatic run_instr(input string tag);
    exp_t e;
    step(5);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (pc !== e.pc || flags !== e.flags || dout !== e.dout) begin
        miscompares++;
        $display("FAIL %s: got pc=%0d flags=%b dout=%h, want pc=%0d flags=%b dout=%h",
                 tag, pc, flags, dout, e.pc, e.flags, e.dout);
      end
    end
  endtask

  task automatic run_all(input string tag);
    while (sb.size() > 0) run_instr(tag);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step(2);
    vectors++;
    if (pc !== 4'd0 || flags !== 4'd0 || dout !== 16'd0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got pc=%0d flags=%b dout=%h halted=%b, want 0 0000 0000 0",
               pc, flags, dout, halted);
    end
  endtask

  task automatic test_add_latency();
    prog = '{ins_i(MOV, 1, 0, 16'd5), ins_i(ADD, 2, 1, 16'd3),
             ins_i(STOREREG, 0, 2, 16'd0), ins_i(SENDDOUT, 0, 0, 16'd0)};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b0000, 16'h0);
    push(3, 4'b0000, 16'h0); push(4, 4'b0000, 16'h0008);
    step(1);
    vectors++;
    if (pc !== 4'd0) begin
      miscompares++;
      $display("FAIL latency_fetch: got pc=%0d, want 0", pc);
    end
    step(1);
    vectors++;
    if (pc !== 4'd1) begin
      miscompares++;
      $display("FAIL latency_exec: got pc=%0d, want 1", pc);
    end
    step(1);
    // the remaining three cycles of the first instruction are the wait phase
    sb.pop_front();
    step(2);
    vectors++;
    if (pc !== 4'd1 || flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL mov_done: got pc=%0d flags=%b, want 1 0000", pc, flags);
    end
    run_all("add");
  endtask

  task automatic test_carry_jump();
    prog = '{ins_i(MOV, 1, 0, 16'hFFFF), ins_i(ADD, 2, 1, 16'd1), ins_i(JCARRY, 0, 0, 16'd6),
             {NOPOP, 27'b0}, {NOPOP, 27'b0}, {NOPOP, 27'b0},
             ins_i(STOREREG, 0, 2, 16'd1), ins_i(SENDDOUT, 0, 0, 16'd1)};
    load_prog();
    push(1, 4'b1000, 16'h0); push(2, 4'b0101, 16'h0); push(6, 4'b0101, 16'h0);
    push(7, 4'b0101, 16'h0); push(8, 4'b0101, 16'h0);
    run_all("carry_jump");
  endtask

  task automatic test_overflow();
    prog = '{ins_i(MOV, 1, 0, 16'h7FFF), ins_i(ADD, 2, 1, 16'd1), ins_i(JNOOVF, 0, 0, 16'd9),
             ins_i(STOREREG, 0, 2, 16'd3), ins_i(SENDDOUT, 0, 0, 16'd3), ins_i(JOVF, 0, 0, 16'd8)};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b1010, 16'h0); push(3, 4'b1010, 16'h0);
    push(4, 4'b1010, 16'h0); push(5, 4'b1010, 16'h8000); push(8, 4'b1010, 16'h8000);
    run_all("overflow");
  endtask

  task automatic test_mul();
    prog = '{ins_i(MOV, 1, 0, 16'd300), ins_i(MUL, 3, 1, 16'd300), ins_r(MOVSGPR, 4, 0, 0),
             ins_i(STOREREG, 0, 3, 16'd4), ins_i(SENDDOUT, 0, 0, 16'd4),
             ins_i(STOREREG, 0, 4, 16'd5), ins_i(SENDDOUT, 0, 0, 16'd5)};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b0000, 16'h0); push(3, 4'b0000, 16'h0);
    push(4, 4'b0000, 16'h0); push(5, 4'b0000, 16'h5F90); push(6, 4'b0000, 16'h5F90);
    push(7, 4'b0000, 16'h0001);
    run_all("mul");
  endtask

  task automatic test_din_path();
    din = 16'hABCD;
    prog = '{ins_i(STOREDIN, 0, 0, 16'd2), ins_i(SENDREG, 5, 0, 16'd2),
             ins_i(STOREREG, 0, 5, 16'd6), ins_i(SENDDOUT, 0, 0, 16'd6),
             ins_i(SENDDOUT, 0, 0, 16'd2)};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b0000, 16'h0); push(3, 4'b0000, 16'h0);
    push(4, 4'b0000, 16'hABCD); push(5, 4'b0000, 16'hABCD);
    run_instr("storedin");
    din = 16'h0000;
    run_all("din_path");
  endtask

  task automatic test_logic_undef();
    prog = '{ins_i(MOV, 1, 0, 16'h0F0F), ins_i(RXOR, 2, 1, 16'hFFFF), ins_i(RNOT, 3, 0, 16'h0),
             ins_r(SUB, 4, 1, 1), ins_i(STOREREG, 0, 2, 16'd7), ins_i(SENDDOUT, 0, 0, 16'd7),
             {UNDEF, 27'h7FFFFFF}};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b1000, 16'h0); push(3, 4'b1000, 16'h0);
    push(4, 4'b0100, 16'h0); push(5, 4'b0100, 16'h0); push(6, 4'b0100, 16'hF0F0);
    push(7, 4'b0100, 16'hF0F0);
    run_all("logic_undef");
  endtask

  task automatic test_halt_resume_reset();
    int bad;
    prog = '{ins_i(MOV, 1, 0, 16'h1234), {NOPOP, 27'b0}, {NOPOP, 27'b0}, ins_i(HALT, 0, 0, 0),
             ins_i(STOREREG, 0, 1, 16'd8), ins_i(SENDDOUT, 0, 0, 16'd8),
             ins_i(MOV, 1, 0, 16'h5555)};
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b0000, 16'h0); push(3, 4'b0000, 16'h0);
    run_all("pre_halt");
    step(2);
    vectors++;
    if (halted !== 1'b1 || pc !== 4'd3) begin
      miscompares++;
      $display("FAIL halt_enter: got halted=%b pc=%0d, want 1 3", halted, pc);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (halted !== 1'b1 || pc !== 4'd3) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL halt_hold: %0d of 20 cycles left halt, want 0", bad);
    end
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    vectors++;
    if (halted !== 1'b0 || pc !== 4'd4) begin
      miscompares++;
      $display("FAIL resume: got halted=%b pc=%0d, want 0 4", halted, pc);
    end
    push(5, 4'b0000, 16'h0); push(6, 4'b0000, 16'h1234);
    run_all("post_resume");
    step(1);
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (pc !== 4'd0 || dout !== 16'd0 || flags !== 4'd0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_exec: got pc=%0d dout=%h flags=%b halted=%b, want 0 0000 0000 0",
               pc, dout, flags, halted);
    end
    prog = '{ins_i(STOREREG, 0, 1, 16'd8), ins_i(SENDDOUT, 0, 0, 16'd8)};
    step(1);
    load_prog();
    push(1, 4'b0000, 16'h0); push(2, 4'b0000, 16'h0);
    run_all("gpr_reset");
  endtask

  initial begin
    sys_rst    = 1'b1;
    din        = '0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    resume     = 1'b0;
    test_reset();
    test_add_latency();
    test_carry_jump();
    test_overflow();
    test_mul();
    test_din_path();
    test_logic_undef();
    test_halt_resume_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
